// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester arbiter sharing one memory port between the
// core (port 0) and a second master (port 1). Live strobes pass straight
// through when granted; losing strobes are latched and replayed later, with
// busy held until the replay completes.
// Build option: define ARB_FIXED_PRIORITY_EN to make port 0 win every tie;
// by default ties are broken round-robin.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s0_addr,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wmask,
    input  logic                    s0_rstrb,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic                    s0_rbusy,
    output logic                    s0_wbusy,
    input  logic [ADDR_WIDTH-1:0]   s1_addr,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wmask,
    input  logic                    s1_rstrb,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic                    s1_rbusy,
    output logic                    s1_wbusy,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wmask,
    output logic                    m_rstrb,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    m_owner
);
    localparam int MW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {P_IDLE = 2'd0, P_WAIT = 2'd1, P_RESP = 2'd2} pstate_t;

    // Requester side gathered into packed per-port arrays
    logic [1:0][ADDR_WIDTH-1:0] s_addr;
    logic [1:0][DATA_WIDTH-1:0] s_wdata;
    logic [1:0][MW-1:0]         s_wmask;
    logic [1:0]                 s_rstrb;
    logic [1:0][DATA_WIDTH-1:0] s_rdata_v;
    logic [1:0]                 s_rbusy, s_wbusy;

    assign s_addr  = {s1_addr, s0_addr};
    assign s_wdata = {s1_wdata, s0_wdata};
    assign s_wmask = {s1_wmask, s0_wmask};
    assign s_rstrb = {s1_rstrb, s0_rstrb};

    assign s0_rdata = s_rdata_v[0];
    assign s1_rdata = s_rdata_v[1];
    assign s0_rbusy = s_rbusy[0];
    assign s1_rbusy = s_rbusy[1];
    assign s0_wbusy = s_wbusy[0];
    assign s1_wbusy = s_wbusy[1];

    logic [1:0]                 is_wr, strobe, in_wait, in_resp, req_rd;
    logic [1:0]                 cand, grant;
    logic [1:0][ADDR_WIDTH-1:0] pend_addr;
    logic [1:0][DATA_WIDTH-1:0] pend_wdata;
    logic [1:0][MW-1:0]         pend_wmask;
    logic [1:0]                 pend_wr;
    logic                       issue, owner;

    // A port competes if it holds a latched request or strobes now; a strobe
    // while already waiting is illegal and simply ignored (the latched one wins).
    assign cand = reset ? 2'b00 : (in_wait | strobe);

`ifdef ARB_FIXED_PRIORITY_EN
    // Core always wins; port 1 may starve while port 0 keeps requesting.
    assign grant[0] = cand[0];
    assign grant[1] = cand[1] & ~cand[0];
`else
    logic last_grant;

    // On a tie, the port that did not issue last goes first.
    assign grant[0] = cand[0] & (~cand[1] | last_grant);
    assign grant[1] = cand[1] & (~cand[0] | ~last_grant);

    // Remember the most recent issuer; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (issue)
            last_grant <= owner;
    end
`endif

    assign issue   = |grant;
    assign owner   = grant[1];
    assign m_owner = owner;

    // Downstream mux: replay a latched request, or pass live inputs through.
    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_wmask = '0;
        m_rstrb = 1'b0;
        if (issue) begin
            if (in_wait[owner]) begin
                m_addr  = pend_addr[owner];
                m_wdata = pend_wdata[owner];
                m_wmask = pend_wr[owner] ? pend_wmask[owner] : '0;
                m_rstrb = ~pend_wr[owner];
            end else begin
                m_addr  = s_addr[owner];
                m_wdata = s_wdata[owner];
                m_wmask = s_wmask[owner];
                m_rstrb = ~is_wr[owner];
            end
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_port
        pstate_t               state;
        logic [ADDR_WIDTH-1:0] p_addr;
        logic [DATA_WIDTH-1:0] p_wdata;
        logic [MW-1:0]         p_wmask;
        logic                  p_wr;
        logic [DATA_WIDTH-1:0] rdata_hold;

        // A write mask takes precedence over a simultaneous read strobe.
        assign is_wr[n]   = |s_wmask[n];
        assign strobe[n]  = s_rstrb[n] | is_wr[n];
        assign in_wait[n] = (state == P_WAIT);
        assign in_resp[n] = (state == P_RESP);
        assign req_rd[n]  = in_wait[n] ? ~p_wr : ~is_wr[n];

        assign pend_addr[n]  = p_addr;
        assign pend_wdata[n] = p_wdata;
        assign pend_wmask[n] = p_wmask;
        assign pend_wr[n]    = p_wr;

        assign s_rbusy[n]   = in_wait[n] & ~p_wr;
        assign s_wbusy[n]   = in_wait[n] &  p_wr;
        assign s_rdata_v[n] = in_resp[n] ? m_rdata : rdata_hold;

        // Per-port request FSM, pending-request latch and read-data hold.
        always_ff @(posedge clk) begin
            if (reset) begin
                state      <= P_IDLE;
                p_addr     <= '0;
                p_wdata    <= '0;
                p_wmask    <= '0;
                p_wr       <= 1'b0;
                rdata_hold <= '0;
            end else begin
                if (state == P_RESP)
                    rdata_hold <= m_rdata;
                if (state == P_WAIT) begin
                    if (grant[n])
                        state <= req_rd[n] ? P_RESP : P_IDLE;
                end else if (strobe[n]) begin
                    if (grant[n]) begin
                        state <= req_rd[n] ? P_RESP : P_IDLE;
                    end else begin
                        state   <= P_WAIT;
                        p_addr  <= s_addr[n];
                        p_wdata <= s_wdata[n];
                        p_wmask <= s_wmask[n];
                        p_wr    <= is_wr[n];
                    end
                end else begin
                    state <= P_IDLE;
                end
            end
        end

        // Requesters must not strobe again while their latched request waits.
        always @(posedge clk) begin
            if (!reset && in_wait[n])
                assert (!strobe[n]) else $error("port %0d strobed while waiting", n);
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: behavioural RAM on the memory side,
// a reference memory image for expected read data, and per-port scoreboards.
module tb_mem_bus_arbiter;
    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] s0_addr, s1_addr, m_addr;
    logic [DW-1:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata, m_wdata, m_rdata;
    logic [3:0]    s0_wmask, s1_wmask, m_wmask;
    logic          s0_rstrb, s1_rstrb, s0_rbusy, s1_rbusy, s0_wbusy, s1_wbusy;
    logic          m_rstrb, m_owner;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .s0_addr(s0_addr), .s0_wdata(s0_wdata), .s0_wmask(s0_wmask), .s0_rstrb(s0_rstrb),
        .s0_rdata(s0_rdata), .s0_rbusy(s0_rbusy), .s0_wbusy(s0_wbusy),
        .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wmask(s1_wmask), .s1_rstrb(s1_rstrb),
        .s1_rdata(s1_rdata), .s1_rbusy(s1_rbusy), .s1_wbusy(s1_wbusy),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rstrb(m_rstrb),
        .m_rdata(m_rdata), .m_owner(m_owner)
    );

    function automatic logic [31:0] init_word(int i);
        if (i == 4)  return 32'hDEADBEEF;
        if (i == 12) return 32'h11223344;
        return 32'h1000_0000 + i * 32'h0001_0003;
    endfunction

    // Behavioural RAM: 256 words, read data one cycle after m_rstrb
    logic [31:0] ram [0:255];
    bit          ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_init <= 1'b1;
        end else begin
            if (m_rstrb) m_rdata <= ram[m_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (m_wmask[b]) ram[m_addr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference memory image and expected-read scoreboards
    logic [31:0] mdl_mem [0:255];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    // Monitor state
    int   cyc = 0;
    bit   [1:0] rd_wait = 2'b00;
    int   rd_at0 = 0, rd_at1 = 0;
    int   run0 = 0, run1 = 0;
    bit   rr_win = 1'b0;
    bit   have_last = 1'b0;
    logic last_own = 1'b0;
    int   alt_err = 0, iss0 = 0, iss1 = 0;
    bit   busy_long = 1'b0;

    logic b0, b1, st0, st1;
    assign b0  = s0_rbusy | s0_wbusy;
    assign b1  = s1_rbusy | s1_wbusy;
    assign st0 = s0_rstrb & (s0_wmask == 4'h0);
    assign st1 = s1_rstrb & (s1_wmask == 4'h0);

    // Completes outstanding reads against the scoreboard and gathers arbitration stats.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            rd_wait <= 2'b00;
            exp_q0.delete();
            exp_q1.delete();
            run0 <= 0;
            run1 <= 0;
        end else begin
            if (rd_wait[0]) begin
                if (!s0_rbusy) begin
                    if (exp_q0.size() > 0) chk("rd0_data", s0_rdata, exp_q0.pop_front());
                    else chk("rd0_q", 32'(exp_q0.size()), 32'd1);
                    rd_wait[0] <= st0;
                    rd_at0     <= cyc;
                end else if (cyc - rd_at0 > 4) begin
                    chk("rd0_latency", 32'(cyc - rd_at0), 32'd1);
                    rd_wait[0] <= 1'b0;
                end
            end else if (st0) begin
                rd_wait[0] <= 1'b1;
                rd_at0     <= cyc;
            end
            if (rd_wait[1]) begin
                if (!s1_rbusy) begin
                    if (exp_q1.size() > 0) chk("rd1_data", s1_rdata, exp_q1.pop_front());
                    else chk("rd1_q", 32'(exp_q1.size()), 32'd1);
                    rd_wait[1] <= st1;
                    rd_at1     <= cyc;
                end else if (cyc - rd_at1 > 4) begin
                    chk("rd1_latency", 32'(cyc - rd_at1), 32'd1);
                    rd_wait[1] <= 1'b0;
                end
            end else if (st1) begin
                rd_wait[1] <= 1'b1;
                rd_at1     <= cyc;
            end
            run0 <= b0 ? run0 + 1 : 0;
            run1 <= b1 ? run1 + 1 : 0;
        end
        if (!rr_win) begin
            have_last <= 1'b0;
            alt_err   <= 0;
            iss0      <= 0;
            iss1      <= 0;
            busy_long <= 1'b0;
        end else begin
            if ((b0 && run0 >= 1) || (b1 && run1 >= 1)) busy_long <= 1'b1;
            if (m_rstrb || m_wmask != 4'h0) begin
                if (have_last && m_owner == last_own) alt_err <= alt_err + 1;
                last_own  <= m_owner;
                have_last <= 1'b1;
                if (m_owner) iss1 <= iss1 + 1;
                else         iss0 <= iss0 + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        s0_rstrb = 1'b0; s1_rstrb = 1'b0;
        s0_wmask = 4'h0; s1_wmask = 4'h0;
    endtask

    task automatic rd(int port, logic [AW-1:0] addr);
        if (port == 0) begin
            s0_addr = addr; s0_rstrb = 1'b1;
            exp_q0.push_back(mdl_mem[addr[9:2]]);
        end else begin
            s1_addr = addr; s1_rstrb = 1'b1;
            exp_q1.push_back(mdl_mem[addr[9:2]]);
        end
    endtask

    task automatic wr(int port, logic [AW-1:0] addr, logic [DW-1:0] data, logic [3:0] mask);
        for (int b = 0; b < 4; b++)
            if (mask[b]) mdl_mem[addr[9:2]][b*8 +: 8] = data[b*8 +: 8];
        if (port == 0) begin
            s0_addr = addr; s0_wdata = data; s0_wmask = mask;
        end else begin
            s1_addr = addr; s1_wdata = data; s1_wmask = mask;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, guard;
        for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);
        reset = 1'b1;
        s0_addr = '0; s0_wdata = '0; s0_wmask = '0; s0_rstrb = 1'b0;
        s1_addr = '0; s1_wdata = '0; s1_wmask = '0; s1_rstrb = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_s0_rbusy", s0_rbusy, 0);
        chk("rst_s0_wbusy", s0_wbusy, 0);
        chk("rst_s1_rbusy", s1_rbusy, 0);
        chk("rst_s1_wbusy", s1_wbusy, 0);
        chk("rst_m_rstrb",  m_rstrb, 0);
        chk("rst_m_wmask",  m_wmask, 0);
        chk("rst_m_owner",  m_owner, 0);
        chk("rst_s0_rdata", s0_rdata, 0);
        chk("rst_s1_rdata", s1_rdata, 0);

        // Lone port-0 read passes straight through
        tick();
        rd(0, 24'h000010);
        @(negedge clk);
        chk("lone_m_rstrb", m_rstrb, 1);
        chk("lone_m_owner", m_owner, 0);
        chk("lone_m_addr",  m_addr, 32'h10);
        tick();
        @(negedge clk);
        chk("lone_s0_rbusy", s0_rbusy, 0);
        chk("lone_s0_rdata", s0_rdata, 32'hDEADBEEF);

        // Simultaneous read (p0) and write (p1) after reset
        do_reset();
        rd(0, 24'h000020);
        wr(1, 24'h000024, 32'h12345678, 4'hF);
        @(negedge clk);
        chk("sim_T_owner",   m_owner, 0);
        chk("sim_T_rstrb",   m_rstrb, 1);
        chk("sim_T_s1wbusy", s1_wbusy, 0);
        tick();
        @(negedge clk);
        chk("sim_T1_owner",   m_owner, 1);
        chk("sim_T1_wmask",   m_wmask, 4'hF);
        chk("sim_T1_addr",    m_addr, 32'h24);
        chk("sim_T1_wdata",   m_wdata, 32'h12345678);
        chk("sim_T1_s1wbusy", s1_wbusy, 1);
        tick();
        rd(0, 24'h000024);
        @(negedge clk);
        chk("sim_T2_s1wbusy", s1_wbusy, 0);
        tick();
        tick();

        // Byte write into a known word, then read it back
        wr(1, 24'h000030, 32'h00AB0000, 4'b0100);
        tick();
        rd(1, 24'h000030);
        tick();
        tick();
        chk("bytewr_model", mdl_mem[12], 32'h11AB3344);

        // Reset while port 1 holds a latched read
        rd(0, 24'h000040);
        rd(1, 24'h000044);
        @(negedge clk);
        chk("midrst_T_s1rbusy", s1_rbusy, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_wait_s1rbusy", s1_rbusy, 1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_s1rbusy", s1_rbusy, 0);
        chk("midrst_s0rbusy", s0_rbusy, 0);
        chk("midrst_rstrb",   m_rstrb, 0);
        tick();
        @(negedge clk);
        chk("midrst_rstrb2",   m_rstrb, 0);
        chk("midrst_s1rbusy2", s1_rbusy, 0);

`ifndef ARB_FIXED_PRIORITY_EN
        // Both ports read at every free cycle: grants must alternate
        do_reset();
        rr_win = 1'b1;
        c0 = 0; c1 = 0; guard = 0;
        while ((c0 < 10 || c1 < 10) && guard < 60) begin
            if (!s0_rbusy && c0 < 10) begin rd(0, 24'h000100 + 24'(4 * c0)); c0++; end
            if (!s1_rbusy && c1 < 10) begin rd(1, 24'h000200 + 24'(4 * c1)); c1++; end
            tick();
            guard++;
        end
        chk("rr_guard", (guard < 60) ? 1 : 0, 1);
        repeat (3) tick();
        @(negedge clk);
        chk("rr_alt_err",   alt_err, 0);
        chk("rr_iss0",      iss0, 10);
        chk("rr_iss1",      iss1, 10);
        chk("rr_busy_long", busy_long, 0);
        rr_win = 1'b0;
`else
        // Port 0 hogs the bus; port 1 waits until port 0 pauses
        do_reset();
        rd(0, 24'h000100);
        rd(1, 24'h000050);
        for (int k = 1; k < 5; k++) begin
            tick();
            rd(0, 24'h000100 + 24'(4 * k));
            @(negedge clk);
            chk("fix_s1rbusy", s1_rbusy, 1);
            chk("fix_owner",   m_owner, 0);
        end
        tick();
        @(negedge clk);
        chk("fix_p1_owner", m_owner, 1);
        chk("fix_p1_rstrb", m_rstrb, 1);
        tick();
        @(negedge clk);
        chk("fix_p1_done", s1_rbusy, 0);
`endif

        repeat (3) tick();
        @(negedge clk);
        chk("q0_empty", 32'(exp_q0.size()), 0);
        chk("q1_empty", 32'(exp_q1.size()), 0);
        chk("no_wait",  rd_wait, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
